// File: rtl/router_port_rx_if.sv
// Serial router-lane input plus the rebuilt byte stream and packet status.
// The receiver takes the slave view; whoever drives the lane takes the master view.
interface router_port_rx_if #(
    parameter int LEN_W = 8
);
    logic             dout;
    logic             frameo_n;
    logic             valido_n;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_sop;
    logic             byte_eop;
    logic [LEN_W-1:0] pkt_len;
    logic             pkt_err;
    logic [1:0]       err_code;

    modport master (
        output dout, frameo_n, valido_n,
        input  byte_data, byte_valid, byte_sop, byte_eop, pkt_len, pkt_err, err_code
    );

    modport slave (
        input  dout, frameo_n, valido_n,
        output byte_data, byte_valid, byte_sop, byte_eop, pkt_len, pkt_err, err_code
    );
endinterface

// File: rtl/router_port_rx.sv
// Deserializes one router output lane (LSB first) into a byte stream with
// sop/eop markers, packet length and a sticky protocol error code.
module router_port_rx #(
    parameter int MAX_BYTES = 64,
    parameter int TIMEOUT   = 16,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    router_port_rx_if.slave  rx
);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RECV  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           state_r;
    logic [7:0]       shift_r;
    logic [2:0]       bit_cnt_r;
    logic [LEN_W-1:0] byte_cnt_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic [7:0]       byte_data_r;
    logic             byte_valid_r;
    logic             byte_sop_r;
    logic             byte_eop_r;
    logic [LEN_W-1:0] pkt_len_r;
    logic             pkt_err_r;
    logic [1:0]       err_code_r;

    logic [7:0]       byte_next_s;
    logic             accept_s;
    logic             byte_done_s;
    logic             overflow_s;
    logic             idle_hit_s;

    // Byte as it would look with the current bit inserted, plus per-cycle event decode
    always_comb begin
        byte_next_s            = shift_r;
        byte_next_s[bit_cnt_r] = rx.dout;
        accept_s               = ~rx.valido_n;
        byte_done_s            = accept_s && (bit_cnt_r == 3'd7);
        overflow_s             = byte_cnt_r >= LEN_W'(MAX_BYTES);
        idle_hit_s             = idle_cnt_r == IDLE_W'(TIMEOUT - 1);
    end

    // Receive FSM with registered byte stream and error outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_SYNC;
            shift_r      <= 8'd0;
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= {LEN_W{1'b0}};
            idle_cnt_r   <= {IDLE_W{1'b0}};
            byte_data_r  <= 8'd0;
            byte_valid_r <= 1'b0;
            byte_sop_r   <= 1'b0;
            byte_eop_r   <= 1'b0;
            pkt_len_r    <= {LEN_W{1'b0}};
            pkt_err_r    <= 1'b0;
            err_code_r   <= 2'd0;
        end else begin
            byte_valid_r <= 1'b0;
            byte_sop_r   <= 1'b0;
            byte_eop_r   <= 1'b0;
            pkt_err_r    <= 1'b0;
            case (state_r)
                ST_SYNC: begin
                    // Coming out of reset mid-packet: wait for a frame boundary first
                    if (rx.frameo_n) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    byte_cnt_r <= {LEN_W{1'b0}};
                    bit_cnt_r  <= 3'd0;
                    idle_cnt_r <= {IDLE_W{1'b0}};
                    if (!rx.frameo_n) begin
                        state_r <= ST_RECV;
                        if (accept_s) begin
                            shift_r[0] <= rx.dout;
                            bit_cnt_r  <= 3'd1;
                        end else begin
                            idle_cnt_r <= IDLE_W'(1);
                        end
                    end
                end
                ST_RECV: begin
                    if (rx.frameo_n) begin
                        state_r    <= ST_IDLE;
                        bit_cnt_r  <= 3'd0;
                        byte_cnt_r <= {LEN_W{1'b0}};
                        idle_cnt_r <= {IDLE_W{1'b0}};
                        if (byte_done_s && !overflow_s) begin
                            byte_data_r  <= byte_next_s;
                            byte_valid_r <= 1'b1;
                            byte_sop_r   <= (byte_cnt_r == {LEN_W{1'b0}});
                            byte_eop_r   <= 1'b1;
                            pkt_len_r    <= byte_cnt_r + LEN_W'(1);
                        end else if (byte_done_s) begin
                            // Frame already closed, so no drain is needed after an overflow here
                            pkt_err_r  <= 1'b1;
                            err_code_r <= 2'd3;
                        end else begin
                            pkt_err_r  <= 1'b1;
                            err_code_r <= 2'd1;
                        end
                    end else if (accept_s) begin
                        shift_r    <= byte_next_s;
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        idle_cnt_r <= {IDLE_W{1'b0}};
                        if (byte_done_s && overflow_s) begin
                            pkt_err_r  <= 1'b1;
                            err_code_r <= 2'd3;
                            state_r    <= ST_DRAIN;
                        end else if (byte_done_s) begin
                            byte_data_r  <= byte_next_s;
                            byte_valid_r <= 1'b1;
                            byte_sop_r   <= (byte_cnt_r == {LEN_W{1'b0}});
                            byte_cnt_r   <= byte_cnt_r + LEN_W'(1);
                        end
                    end else if (idle_hit_s) begin
                        pkt_err_r  <= 1'b1;
                        err_code_r <= 2'd2;
                        state_r    <= ST_DRAIN;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                    end
                end
                ST_DRAIN: begin
                    bit_cnt_r  <= 3'd0;
                    byte_cnt_r <= {LEN_W{1'b0}};
                    idle_cnt_r <= {IDLE_W{1'b0}};
                    if (rx.frameo_n) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_SYNC;
                end
            endcase
        end
    end

    assign rx.byte_data  = byte_data_r;
    assign rx.byte_valid = byte_valid_r;
    assign rx.byte_sop   = byte_sop_r;
    assign rx.byte_eop   = byte_eop_r;
    assign rx.pkt_len    = pkt_len_r;
    assign rx.pkt_err    = pkt_err_r;
    assign rx.err_code   = err_code_r;
endmodule

// File: doc/router_port_rx.md
Name: router_port_rx

Overview:
- Receive-side deserializer for one router output lane.
- Samples the serial `dout`/`frameo_n`/`valido_n` stream that a router port emits and rebuilds it into bytes, LSB first.
- Presents the bytes on a parallel valid/sop/eop stream and reports per-packet length and protocol errors.
- One instance per router output port; used by the scoreboard-side collector and by downstream packet sinks.

Parameters:
- MAX_BYTES, 64, largest legal packet payload in bytes; exceeding it is an overflow error.
- TIMEOUT, 16, consecutive idle cycles (frame low, valid high) allowed inside a packet before abort.
- LEN_W, 8, width of the pkt_len output; must hold MAX_BYTES.

Ports:
- clk  input  1  clock; all sampling on posedge.
- reset_n  input  1  asynchronous active-low reset.
- dout  input  1  serial data bit from router port.
- frameo_n  input  1  active-low frame; low for the whole packet, high on the cycle of the last bit.
- valido_n  input  1  active-low bit-valid qualifier.
- byte_data  output  8  assembled byte.
- byte_valid  output  1  one-cycle pulse, byte_data valid.
- byte_sop  output  1  first byte of packet, qualified by byte_valid.
- byte_eop  output  1  last byte of packet, qualified by byte_valid.
- pkt_len  output  LEN_W  byte count of the completed packet, valid with byte_eop.
- pkt_err  output  1  one-cycle pulse, packet aborted or malformed.
- err_code  output  2  held from last pkt_err: 0 none, 1 partial byte, 2 timeout, 3 overflow.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0; err_code is 0.
  - Shift register, bit_cnt (0..7) and byte_cnt clear.
  - State enters SYNC.
- A bit is accepted on a posedge where valido_n==0 and the FSM is in IDLE or RECV. The bit is placed at position bit_cnt (LSB first).
- A frame end is a posedge with frameo_n==1 while in RECV.
- SYNC: wait for frameo_n==1 sampled, then go to IDLE. This guarantees reset released mid-packet never yields a partial packet.
- IDLE: on frameo_n==0, go to RECV. If valido_n==0 in the same cycle, that bit is accepted as bit 0. If frameo_n==1 and valido_n==0 in IDLE, the bit is ignored.
- RECV:
  - Accepted bit with bit_cnt==7 completes a byte.
  - On the next cycle: byte_valid=1, byte_data=assembled byte, byte_sop=1 iff byte_cnt was 0, byte_eop=1 iff the completing cycle was also a frame end.
  - byte_cnt increments; bit_cnt wraps to 0.
  - Normal end: frame end with valido_n==0 and the bit completing a byte → eop byte emitted, pkt_len=byte_cnt+1, go to IDLE.
  - Partial: frame end with valido_n==0 and bit_cnt<7 before the accept → no byte emitted, pkt_err, err_code=1, go to IDLE.
  - Frame end with valido_n==1 → pkt_err, err_code=1, go to IDLE. No eop is generated for bytes already emitted.
  - Idle counter: counts consecutive cycles with frameo_n==0 and valido_n==1; reset by any accepted bit. At TIMEOUT → pkt_err, err_code=2, go to DRAIN.
  - Overflow: a byte completion that would make byte_cnt exceed MAX_BYTES is suppressed (no byte_valid), then pkt_err, err_code=3, go to DRAIN.
- DRAIN: ignore all bits; on frameo_n==1, go to IDLE.
- Latency:
  - Byte output is 1 cycle after the posedge that samples the 8th bit.
  - pkt_err is 1 cycle after the detecting posedge.
- On every return to IDLE: bit_cnt, byte_cnt and the idle counter clear.
- Back-to-back packets: frameo_n low on the cycle immediately after a frame end starts a new packet with no lost bits.
- Zero-byte packets are impossible; the minimum legal packet is 8 bits.
- pkt_len and byte_data hold their value until the next update; err_code holds until the next error.

Test Plan:
- 2-byte packet 0xA5, 0x3C, LSB first, 16 contiguous valid cycles, frameo_n high on bit 16 → byte_valid pulses with 0xA5 (sop=1) and 0x3C (eop=1, pkt_len=2); pkt_err stays 0.
- Same packet with 3 valid_n-high gaps (less than TIMEOUT) inserted mid-byte → identical outputs, each byte delayed by the gap count.
- 12-bit packet (frame ends after bit 12) → one byte emitted with sop=1, eop=0; pkt_err pulse; err_code=1.
- frameo_n held low with valido_n high for 16 cycles after 1 byte → pkt_err, err_code=2; further bits ignored until frameo_n high; next packet 0x5A received correctly.
- 65-byte packet with MAX_BYTES=64 → 64 bytes emitted, 65th suppressed, pkt_err with err_code=3, no eop.
- reset_n pulsed low at bit 5 of a byte and released with frameo_n still low → no output for the rest of that packet; the following packet 0xFF, eop with pkt_len=1, is received cleanly.
